mem_bridge: RTL and testbench

Memory bus bridge directly downstream of the CPU core. It accepts the core's data read, data write and instruction-fetch requests, and runs them as 16-bit beats on a single req/ack backend bus (SDRAM/IO controller). It returns the handshake signals the core consumes: busy, ready, cack, 16-bit read data and the 32-bit assembled instruction. It serialises one transaction at a time and guards the backend with an ack timeout.

---
 rtl/mem_bridge.sv | 155 +++++++++++++++
 tb/tb_mem_bridge.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bridge.sv
`timescale 1ns/1ps
// mem_bridge: serialises core data reads, data writes and instruction fetches
// into 16-bit req/ack beats on the backend bus. It runs one transaction at a
// time and aborts any beat whose ack does not arrive within TIMEOUT cycles.
module mem_bridge #(
  parameter int          TIMEOUT  = 64,
  parameter logic [15:0] ERR_DATA = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [19:0] c_addr,
  input  logic [15:0] c_data,
  input  logic        c_read,
  input  logic        c_write,
  input  logic        c_instr,
  input  logic [15:0] c_pc,
  input  logic        c_read_done,
  output logic [15:0] c_mem_bus,
  output logic [31:0] c_instr_bus,
  output logic        c_busy,
  output logic        c_ready,
  output logic        c_cack,
  output logic [20:0] m_addr,
  output logic [15:0] m_wdata,
  output logic        m_we,
  output logic        m_req,
  input  logic        m_ack,
  input  logic [15:0] m_rdata,
  output logic        err
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] T_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, DRD, DWR, ILO, IHI, HOLD} state_t;

  state_t        state_reg, state_next;
  logic [19:0]   addr_reg;
  logic [15:0]   wdata_reg;
  logic [15:0]   pc_reg;
  logic          gap_reg;     // forces one m_req=0 cycle between the two fetch beats
  logic [CW-1:0] tcnt_reg;

  logic        accept;
  logic        beat_on;
  logic        expire;
  logic        beat_done;
  logic [15:0] beat_data;

  // A beat is on the bus in any transfer state except the inter-beat gap.
  assign beat_on   = ((state_reg == DRD) || (state_reg == DWR) ||
                      (state_reg == ILO) || (state_reg == IHI)) && !gap_reg;
  // A real ack on the expiry cycle wins over the timeout.
  assign expire    = beat_on && !m_ack && (tcnt_reg == T_LAST);
  assign beat_done = beat_on && (m_ack || expire);
  assign beat_data = m_ack ? m_rdata : ERR_DATA;
  assign accept    = (state_reg == IDLE) && (c_write || c_read);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  // Next-state logic: requests are only sampled in IDLE, writes win over reads.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (c_write)               state_next = DWR;
        else if (c_read && c_instr) state_next = ILO;
        else if (c_read)           state_next = DRD;
      end
      DWR:  if (beat_done)   state_next = IDLE;
      DRD:  if (beat_done)   state_next = HOLD;
      ILO:  if (beat_done)   state_next = IHI;
      IHI:  if (beat_done)   state_next = IDLE;
      HOLD: if (c_read_done) state_next = IDLE;
      default:               state_next = IDLE;
    endcase
  end

  // Output decode: backend address/data come from the captured request, so
  // they stay stable for the whole beat regardless of the core inputs.
  always_comb begin
    m_req   = beat_on;
    m_we    = 1'b0;
    m_wdata = 16'h0000;
    m_addr  = 21'h0;
    c_cack  = accept && rst;
    case (state_reg)
      DRD: m_addr = {1'b0, addr_reg};
      DWR: begin
        m_addr  = {1'b0, addr_reg};
        m_we    = 1'b1;
        m_wdata = wdata_reg;
      end
      ILO: m_addr = {1'b1, 3'b000, pc_reg, 1'b0};
      IHI: m_addr = {1'b1, 3'b000, pc_reg, 1'b1};
      default: ;
    endcase
  end

  // Capture the request on acceptance so the core may move on.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_reg  <= 20'h0;
      wdata_reg <= 16'h0;
      pc_reg    <= 16'h0;
    end else if (accept) begin
      addr_reg  <= c_addr;
      wdata_reg <= c_data;
      pc_reg    <= c_pc;
    end
  end

  // Beat sequencing: inter-beat gap flag and ack timeout counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gap_reg  <= 1'b0;
      tcnt_reg <= '0;
    end else begin
      gap_reg <= (state_reg == ILO) && beat_done;
      if (!beat_on || beat_done) tcnt_reg <= '0;
      else                       tcnt_reg <= tcnt_reg + 1'b1;
    end
  end

  // Core handshake flags and the sticky timeout flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      c_busy  <= 1'b0;
      c_ready <= 1'b0;
      err     <= 1'b0;
    end else begin
      c_busy  <= (state_next != IDLE);
      c_ready <= (((state_reg == DWR) || (state_reg == IHI)) && beat_done) ||
                 (state_next == HOLD);
      err     <= err || expire;
    end
  end

  // Result buses: each is overwritten only by its own completing beat.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      c_mem_bus   <= 16'h0;
      c_instr_bus <= 32'h0;
    end else if (beat_done) begin
      if (state_reg == DRD) c_mem_bus          <= beat_data;
      if (state_reg == ILO) c_instr_bus[15:0]  <= beat_data;
      if (state_reg == IHI) c_instr_bus[31:16] <= beat_data;
    end
  end

endmodule

// File: tb/tb_mem_bridge.sv
`timescale 1ns/1ps
// Bench for mem_bridge: a backend responder with a programmable ack delay and
// a memory, a table of directed transactions, a reset-mid-fetch sequence and
// randomized transactions predicted by a simple memory/latency model.
module tb_mem_bridge;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [19:0] c_addr;
  logic [15:0] c_data;
  logic        c_read, c_write, c_instr;
  logic [15:0] c_pc;
  logic        c_read_done;
  logic [15:0] c_mem_bus;
  logic [31:0] c_instr_bus;
  logic        c_busy, c_ready, c_cack;
  logic [20:0] m_addr;
  logic [15:0] m_wdata;
  logic        m_we, m_req, m_ack;
  logic [15:0] m_rdata;
  logic        err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_bridge #(.TIMEOUT(TO), .ERR_DATA(16'hFFFF)) dut (
    .clk(clk), .rst(rst), .c_addr(c_addr), .c_data(c_data), .c_read(c_read),
    .c_write(c_write), .c_instr(c_instr), .c_pc(c_pc), .c_read_done(c_read_done),
    .c_mem_bus(c_mem_bus), .c_instr_bus(c_instr_bus), .c_busy(c_busy),
    .c_ready(c_ready), .c_cack(c_cack), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_we(m_we), .m_req(m_req), .m_ack(m_ack), .m_rdata(m_rdata), .err(err)
  );

  // ---------------- backend responder ----------------
  int          ack_delay  = 0;   // m_req cycles before ack (0 = first cycle)
  bit          ack_enable = 1'b1;
  int          req_cnt    = 0;
  int          stable_err = 0;
  logic [20:0] cur_addr;
  logic        cur_we;
  logic [15:0] cur_wd;
  logic [20:0] beat_addr_q[$];
  logic        beat_we_q[$];
  logic [15:0] beat_wd_q[$];
  logic [15:0] bmem [logic [20:0]];

  function automatic logic [15:0] bdefault(input logic [20:0] a);
    return a[15:0] ^ 16'h5A5A;
  endfunction

  initial begin
    m_ack   = 1'b0;
    m_rdata = 16'h0;
    forever begin
      @(negedge clk);
      if (m_req) begin
        if (req_cnt == 0) begin
          cur_addr = m_addr; cur_we = m_we; cur_wd = m_wdata;
          beat_addr_q.push_back(m_addr);
          beat_we_q.push_back(m_we);
          beat_wd_q.push_back(m_wdata);
        end else if (m_addr !== cur_addr || m_we !== cur_we || m_wdata !== cur_wd) begin
          stable_err++;
        end
        if (ack_enable && req_cnt == ack_delay) begin
          m_ack = 1'b1;
          if (m_we) begin
            bmem[m_addr] = m_wdata;
            m_rdata = 16'h0;
          end else begin
            m_rdata = bmem.exists(m_addr) ? bmem[m_addr] : bdefault(m_addr);
          end
          req_cnt = 0;
        end else begin
          m_ack = 1'b0;
          m_rdata = 16'($urandom);
          req_cnt++;
        end
      end else begin
        m_ack = 1'b0;
        m_rdata = 16'($urandom);
        req_cnt = 0;
      end
    end
  end

  // ---------------- reference memory for random phase ----------------
  logic [15:0] ref_mem [logic [20:0]];

  function automatic logic [15:0] ref_rd(input logic [20:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : bdefault(a);
  endfunction

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] outs();
    return 128'({c_mem_bus, c_instr_bus, c_busy, c_ready, c_cack,
                 m_addr, m_wdata, m_we, m_req, err});
  endfunction

  typedef struct {
    logic        w, r, i;
    logic [19:0] addr;
    logic [15:0] wd;
    logic [15:0] pc;
    int          dly;       // >= TO means the backend never acks
    int          hold;      // extra HOLD cycles before c_read_done
    int          exp_lat;   // cycles from acceptance edge to c_ready
    logic [31:0] exp_data;  // read data / instruction / written data
    int          exp_beats;
    logic [20:0] exp_a0, exp_a1;
    logic        exp_we;
    logic        exp_err;
  } vec_t;

  function automatic vec_t mk(input logic w, input logic r, input logic i,
                              input logic [19:0] addr, input logic [15:0] wd,
                              input logic [15:0] pc, input int dly, input int hold,
                              input int lat, input logic [31:0] data, input int beats,
                              input logic [20:0] a0, input logic [20:0] a1,
                              input logic we, input logic e);
    vec_t v;
    v.w = w; v.r = r; v.i = i; v.addr = addr; v.wd = wd; v.pc = pc;
    v.dly = dly; v.hold = hold; v.exp_lat = lat; v.exp_data = data;
    v.exp_beats = beats; v.exp_a0 = a0; v.exp_a1 = a1; v.exp_we = we; v.exp_err = e;
    return v;
  endfunction

  // Issue one transaction from a negedge with the bridge idle; returns at a negedge.
  task automatic run_vec(input vec_t v, input string tag);
    int          lat;
    logic [31:0] got;
    bit          hold_ok;
    ack_delay  = v.dly;
    ack_enable = (v.dly < TO);
    beat_addr_q.delete(); beat_we_q.delete(); beat_wd_q.delete();
    stable_err = 0;
    c_write = v.w; c_read = v.r; c_instr = v.i;
    c_addr = v.addr; c_data = v.wd; c_pc = v.pc;
    #1;
    chk({tag, ".cack"}, 128'(c_cack), 128'(1));
    @(posedge clk);
    @(negedge clk);
    c_write = 1'b0; c_read = 1'b0; c_instr = 1'b0;
    c_addr = ~v.addr; c_data = ~v.wd; c_pc = ~v.pc;
    lat = 1;
    while (!c_ready && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, ".latency"}, 128'(lat), 128'(v.exp_lat));
    if (v.w)      got = {16'h0, (beat_wd_q.size() > 0) ? beat_wd_q[0] : 16'h0};
    else if (v.i) got = c_instr_bus;
    else          got = {16'h0, c_mem_bus};
    chk({tag, ".data"}, 128'(got), 128'(v.exp_data));
    chk({tag, ".beats"}, 128'(beat_addr_q.size()), 128'(v.exp_beats));
    if (beat_addr_q.size() > 0) begin
      chk({tag, ".addr0"}, 128'(beat_addr_q[0]), 128'(v.exp_a0));
      chk({tag, ".we"}, 128'(beat_we_q[0]), 128'(v.exp_we));
    end
    if (v.exp_beats == 2 && beat_addr_q.size() > 1)
      chk({tag, ".addr1"}, 128'(beat_addr_q[1]), 128'(v.exp_a1));
    chk({tag, ".err"}, 128'(err), 128'(v.exp_err));
    chk({tag, ".stable"}, 128'(stable_err), 128'(0));
    $display("txn %s w=%0d r=%0d i=%0d addr=%05h pc=%04h dly=%0d lat=%0d data=%08h err=%0d",
             tag, v.w, v.r, v.i, v.addr, v.pc, v.dly, lat, got, err);
    if (v.r && !v.w && !v.i) begin
      hold_ok = 1'b1;
      for (int k = 0; k < v.hold; k++) begin
        @(negedge clk);
        if (!(c_ready && c_busy && c_mem_bus == v.exp_data[15:0])) hold_ok = 1'b0;
      end
      chk({tag, ".hold"}, 128'(hold_ok), 128'(1));
      c_read_done = 1'b1;
      @(negedge clk);
      c_read_done = 1'b0;
      chk({tag, ".release"}, 128'({c_ready, c_busy}), 128'(0));
    end else begin
      @(negedge clk);
      chk({tag, ".pulse"}, 128'({c_ready, c_busy}), 128'(0));
    end
    ack_enable = 1'b1;
  endtask

  // Watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

  vec_t tbl[11];

  initial begin
    vec_t        v;
    bit          found;
    int          kind, dly, hold;
    logic [19:0] a;
    logic [15:0] wd, pc;
    logic [20:0] fa;

    rst = 1'b0;
    c_addr = 20'h0; c_data = 16'h0; c_read = 1'b0; c_write = 1'b0;
    c_instr = 1'b0; c_pc = 16'h0; c_read_done = 1'b0;
    c_write = 1'b1;
    #1;
    chk("reset.outputs", outs(), 128'(0));
    c_write = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("reset.idle", outs(), 128'(0));

    bmem[21'h000010] = 16'hA5A5;
    bmem[21'h100084] = 16'h1234;
    bmem[21'h100085] = 16'h5678;

    //           w r i  addr      wd        pc        dly hold lat data           beats a0          a1          we err
    tbl[0]  = mk(1,0,0, 20'h12345,16'hBEEF, 16'h0000, 3,  0,   5, 32'h0000BEEF, 1, 21'h012345, 21'h0,      1, 0);
    tbl[1]  = mk(0,1,0, 20'h00010,16'h0000, 16'h0000, 0,  5,   2, 32'h0000A5A5, 1, 21'h000010, 21'h0,      0, 0);
    tbl[2]  = mk(0,1,1, 20'h00000,16'h0000, 16'h0042, 0,  0,   4, 32'h56781234, 2, 21'h100084, 21'h100085, 0, 0);
    tbl[3]  = mk(1,1,0, 20'h00020,16'h1111, 16'h0000, 1,  0,   3, 32'h00001111, 1, 21'h000020, 21'h0,      1, 0);
    tbl[4]  = mk(0,1,0, 20'h00020,16'h0000, 16'h0000, 2,  1,   4, 32'h00001111, 1, 21'h000020, 21'h0,      0, 0);
    tbl[5]  = mk(0,1,0, 20'h12345,16'h0000, 16'h0000, 0,  0,   2, 32'h0000BEEF, 1, 21'h012345, 21'h0,      0, 0);
    tbl[6]  = mk(0,1,1, 20'h00000,16'h0000, 16'hFFFF, 1,  0,   6, 32'hA5A5A5A4, 2, 21'h11FFFE, 21'h11FFFF, 0, 0);
    tbl[7]  = mk(0,1,0, 20'h00030,16'h0000, 16'h0000, 7,  2,   9, 32'h00005A6A, 1, 21'h000030, 21'h0,      0, 0);
    tbl[8]  = mk(0,1,0, 20'h00040,16'h0000, 16'h0000, 99, 1,   9, 32'h0000FFFF, 1, 21'h000040, 21'h0,      0, 1);
    tbl[9]  = mk(1,0,0, 20'h00050,16'h0BAD, 16'h0000, 0,  0,   2, 32'h00000BAD, 1, 21'h000050, 21'h0,      1, 1);
    tbl[10] = mk(0,1,0, 20'h00050,16'h0000, 16'h0000, 0,  0,   2, 32'h00000BAD, 1, 21'h000050, 21'h0,      0, 1);

    for (int n = 0; n < 11; n++) run_vec(tbl[n], $sformatf("v%0d", n));

    // Reset while the fetch hi beat is requesting.
    beat_addr_q.delete(); beat_we_q.delete(); beat_wd_q.delete();
    ack_delay = 0; ack_enable = 1'b1;
    c_read = 1'b1; c_instr = 1'b1; c_pc = 16'h0100;
    @(posedge clk);
    @(negedge clk);
    c_read = 1'b0; c_instr = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      #2;
      if (beat_addr_q.size() == 2 && m_req) found = 1'b1;
      else @(negedge clk);
    end
    chk("midfetch.reached_ihi", 128'(found), 128'(1));
    rst = 1'b0;
    #1;
    chk("midfetch.m_req_async", 128'(m_req), 128'(0));
    chk("midfetch.outputs", outs(), 128'(0));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    v = mk(0,1,0, 20'h12345,16'h0, 16'h0, 0, 0, 2, 32'h0000BEEF, 1, 21'h012345, 21'h0, 0, 0);
    run_vec(v, "post_reset");

    // Randomized transactions against the memory/latency model.
    for (int n = 0; n < 40; n++) begin
      kind = int'($urandom_range(0, 2));
      dly  = int'($urandom_range(0, 3));
      hold = int'($urandom_range(0, 3));
      a    = 20'h80000 | 20'($urandom_range(0, 15));
      wd   = 16'($urandom);
      pc   = 16'h2000 + 16'($urandom_range(0, 7));
      if (kind == 0) begin
        v = mk(1,0,0, a, wd, pc, dly, 0, 2 + dly, {16'h0, wd}, 1, {1'b0, a}, 21'h0, 1, 0);
        ref_mem[{1'b0, a}] = wd;
      end else if (kind == 1) begin
        v = mk(0,1,0, a, wd, pc, dly, hold, 2 + dly, {16'h0, ref_rd({1'b0, a})}, 1,
               {1'b0, a}, 21'h0, 0, 0);
      end else begin
        fa = 21'((1 << 20) + 2 * int'(pc));
        v = mk(0,1,1, a, wd, pc, dly, 0, 4 + 2 * dly, {ref_rd(fa + 21'd1), ref_rd(fa)}, 2,
               fa, fa + 21'd1, 0, 0);
      end
      run_vec(v, $sformatf("r%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
